// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART memory-mapped bridge: register offsets,
// STATUS/CTRL bit positions, FSM encoding and the RXDATA empty marker.
package uart_mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TX_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

  // Register offsets, decoded from addr[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_RX_EMPTY = 1;
  localparam int STAT_OVF      = 2;

  // CTRL bit positions
  localparam int CTRL_STALL_EN = 0;
  localparam int CTRL_OVF_CLR  = 1;
  localparam int CTRL_IRQ_EN   = 2;

  // RXDATA value returned when the RX FIFO is empty
  localparam logic [31:0] RXDATA_EMPTY = 32'h0000_0100;

endpackage

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped front end between the core data port and the UART FIFOs.
// Stores to TXDATA push the TX FIFO (optionally stalling while it is full),
// loads from RXDATA pop the RX FIFO. Every access completes with a single
// registered ack pulse, followed by one recovery cycle before the next access.
module uart_mmio_bridge
  import uart_mmio_pkg::*;
#(
  parameter int ADDR_W        = 4,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 16
) (
  input  logic              i_mmio_clk,
  input  logic              i_mmio_rst_n,
  input  logic              i_mmio_req,
  input  logic              i_mmio_we,
  input  logic [ADDR_W-1:0] i_mmio_addr,
  input  logic [31:0]       i_mmio_wdata,
  output logic [31:0]       o_mmio_rdata,
  output logic              o_mmio_ack,
  output logic              o_mmio_irq,
  input  logic              i_mmio_tx_full,
  input  logic              i_mmio_rx_empty,
  input  logic [7:0]        i_mmio_rx_pdata,
  output logic              o_mmio_tx_valid,
  output logic [7:0]        o_mmio_tx_pdata,
  output logic              o_mmio_rx_request
);

  localparam int WAIT_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STALL_TIMEOUT - 1);

  state_e            state_r, state_s;
  logic              ack_r, ack_s;
  logic              tx_valid_r, tx_valid_s;
  logic [7:0]        tx_pdata_r, tx_pdata_s;
  logic              rx_request_r, rx_request_s;
  logic [31:0]       rdata_r, rdata_s;
  logic [CNT_W-1:0]  tx_count_r, tx_count_s;
  logic              ovf_r, ovf_s;
  logic              stall_en_r, stall_en_s;
  logic              irq_en_r, irq_en_s;
  logic              irq_r;
  logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_s;
  logic [31:0]       status_s;
  logic [31:0]       ctrl_s;
  logic [1:0]        reg_sel_s;
  logic              unused_s;

  assign reg_sel_s = i_mmio_addr[3:2];
  assign unused_s  = ^{i_mmio_addr, i_mmio_wdata};

  // Assemble STATUS and CTRL read views from live flags and current state
  always_comb begin
    status_s                = 32'h0000_0000;
    status_s[STAT_TX_FULL]  = i_mmio_tx_full;
    status_s[STAT_RX_EMPTY] = i_mmio_rx_empty;
    status_s[STAT_OVF]      = ovf_r;
    status_s[31:16]         = 16'(tx_count_r);
    ctrl_s                  = 32'h0000_0000;
    ctrl_s[CTRL_STALL_EN]   = stall_en_r;
    ctrl_s[CTRL_IRQ_EN]     = irq_en_r;
  end

  // Next-state and next-output logic; all outputs are registered below
  always_comb begin
    state_s      = state_r;
    ack_s        = 1'b0;
    tx_valid_s   = 1'b0;
    tx_pdata_s   = 8'h00;
    rx_request_s = 1'b0;
    rdata_s      = 32'h0000_0000;
    tx_count_s   = tx_count_r;
    ovf_s        = ovf_r;
    stall_en_s   = stall_en_r;
    irq_en_s     = irq_en_r;
    wait_cnt_s   = wait_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (i_mmio_req) begin
          state_s = ST_RESP;
          ack_s   = 1'b1;
          case (reg_sel_s)
            REG_TXDATA: begin
              if (!i_mmio_we) begin
                rdata_s = 32'h0000_0000;
              end else if (!i_mmio_tx_full) begin
                tx_valid_s = 1'b1;
                tx_pdata_s = i_mmio_wdata[7:0];
                tx_count_s = tx_count_r + CNT_W'(1);
              end else if (stall_en_r) begin
                state_s    = ST_TX_WAIT;
                ack_s      = 1'b0;
                wait_cnt_s = WAIT_W'(0);
              end else begin
                ovf_s = 1'b1;
              end
            end
            REG_RXDATA: begin
              if (i_mmio_we) begin
                rdata_s = 32'h0000_0000;
              end else if (i_mmio_rx_empty) begin
                rdata_s = RXDATA_EMPTY;
              end else begin
                rdata_s      = {24'h00_0000, i_mmio_rx_pdata};
                rx_request_s = 1'b1;
              end
            end
            REG_STATUS: begin
              rdata_s = i_mmio_we ? 32'h0000_0000 : status_s;
            end
            REG_CTRL: begin
              if (i_mmio_we) begin
                stall_en_s = i_mmio_wdata[CTRL_STALL_EN];
                irq_en_s   = i_mmio_wdata[CTRL_IRQ_EN];
                ovf_s      = i_mmio_wdata[CTRL_OVF_CLR] ? 1'b0 : ovf_r;
              end else begin
                rdata_s = ctrl_s;
              end
            end
            default: begin
              rdata_s = 32'h0000_0000;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_TX_WAIT: begin
        if (!i_mmio_tx_full) begin
          state_s    = ST_RESP;
          ack_s      = 1'b1;
          tx_valid_s = 1'b1;
          tx_pdata_s = i_mmio_wdata[7:0];
          tx_count_s = tx_count_r + CNT_W'(1);
        end else if (wait_cnt_r == WAIT_LAST) begin
          // Give up: drop the byte and flag the overflow
          state_s = ST_RESP;
          ack_s   = 1'b1;
          ovf_s   = 1'b1;
        end else begin
          wait_cnt_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      ST_RESP: begin
        // One recovery cycle: FIFO flags settle before the next sample
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge i_mmio_clk) begin
    if (!i_mmio_rst_n) begin
      state_r      <= ST_IDLE;
      ack_r        <= 1'b0;
      tx_valid_r   <= 1'b0;
      tx_pdata_r   <= 8'h00;
      rx_request_r <= 1'b0;
      rdata_r      <= 32'h0000_0000;
      tx_count_r   <= CNT_W'(0);
      ovf_r        <= 1'b0;
      stall_en_r   <= 1'b1;
      irq_en_r     <= 1'b0;
      irq_r        <= 1'b0;
      wait_cnt_r   <= WAIT_W'(0);
    end else begin
      state_r      <= state_s;
      ack_r        <= ack_s;
      tx_valid_r   <= tx_valid_s;
      tx_pdata_r   <= tx_pdata_s;
      rx_request_r <= rx_request_s;
      rdata_r      <= rdata_s;
      tx_count_r   <= tx_count_s;
      ovf_r        <= ovf_s;
      stall_en_r   <= stall_en_s;
      irq_en_r     <= irq_en_s;
      irq_r        <= irq_en_r & ~i_mmio_rx_empty;
      wait_cnt_r   <= wait_cnt_s;
    end
  end

  assign o_mmio_ack        = ack_r;
  assign o_mmio_tx_valid   = tx_valid_r;
  assign o_mmio_tx_pdata   = tx_pdata_r;
  assign o_mmio_rx_request = rx_request_r;
  assign o_mmio_rdata      = rdata_r;
  assign o_mmio_irq        = irq_r;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Self-checking bench for uart_mmio_bridge: directed table, hand-written
// stall/irq/reset/wrap sequences and randomized accesses against a model.
// A short stall timeout and a narrow counter keep the run small.
module tb_uart_mmio_bridge;

  localparam int ADDR_W = 4;
  localparam int T      = 32;
  localparam int CW     = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] addr = 4'h0;
  logic [31:0]       wdata = 32'h0;
  logic              tx_full = 1'b0;
  logic              rx_empty = 1'b1;
  logic [7:0]        rx_pdata = 8'h00;
  logic [31:0]       rdata;
  logic              ack, irq, txv, rxr;
  logic [7:0]        txd;

  uart_mmio_bridge #(.ADDR_W(ADDR_W), .STALL_TIMEOUT(T), .CNT_W(CW)) dut (
    .i_mmio_clk(clk), .i_mmio_rst_n(rst_n), .i_mmio_req(req), .i_mmio_we(we),
    .i_mmio_addr(addr), .i_mmio_wdata(wdata), .o_mmio_rdata(rdata),
    .o_mmio_ack(ack), .o_mmio_irq(irq), .i_mmio_tx_full(tx_full),
    .i_mmio_rx_empty(rx_empty), .i_mmio_rx_pdata(rx_pdata),
    .o_mmio_tx_valid(txv), .o_mmio_tx_pdata(txd), .o_mmio_rx_request(rxr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_count;
  bit m_ovf, m_stall, m_irq_en;

  typedef struct {
    bit          w;
    logic [3:0]  a;
    logic [31:0] wd;
    bit          full;
    bit          empty;
    logic [7:0]  pd;
    logic [31:0] rd;
    int          lat;
    int          push;
    logic [7:0]  pdx;
    int          pop;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_ovf = 1'b0; m_stall = 1'b1; m_irq_en = 1'b0;
  endtask

  // Register-map behaviour of one access, given flags held for its duration
  task automatic model_step(input bit w, input logic [3:0] a, input logic [31:0] wd,
                            input bit full, input bit empty, input logic [7:0] pd,
                            output logic [31:0] e_rd, output int e_lat, output int e_push,
                            output logic [7:0] e_pd, output int e_pop);
    e_rd = 32'h0; e_lat = 1; e_push = 0; e_pd = 8'h00; e_pop = 0;
    case (a[3:2])
      2'd0: if (w) begin
        if (!full) begin
          e_push = 1; e_pd = wd[7:0];
          m_count = (m_count + 1) % (1 << CW);
        end else begin
          m_ovf = 1'b1;
          if (m_stall) e_lat = T + 1;
        end
      end
      2'd1: if (!w) begin
        if (empty) e_rd = 32'h100;
        else begin e_rd = {24'h0, pd}; e_pop = 1; end
      end
      2'd2: if (!w) e_rd = (32'(m_count) * 65536) + (32'(m_ovf) * 4) + (32'(empty) * 2) + 32'(full);
      default: if (w) begin
        m_stall = wd[0]; m_irq_en = wd[2];
        if (wd[1]) m_ovf = 1'b0;
      end else e_rd = 32'(m_stall) + (32'(m_irq_en) * 4);
    endcase
  endtask

  // Drive one access and observe it until ack plus one cycle after
  task automatic do_access(input bit w, input logic [3:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output int lat, output int pushes,
                           output logic [7:0] pd, output int pops, output bit clean,
                           output logic irq_after);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = wd;
    lat = 0; pushes = 0; pops = 0; pd = 8'h00; rd = 32'h0;
    for (int c = 0; c < T + 8; c++) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (txv) begin pushes++; pd = txd; end
      if (rxr) pops++;
      if (ack) break;
    end
    chk("ack_seen", {31'h0, ack}, 32'h1);
    rd = rdata;
    req = 1'b0; we = 1'b0; wdata = $urandom;
    @(negedge clk);
    clean = !ack && !txv && !rxr && (rdata == 32'h0);
    irq_after = irq;
  endtask

  task automatic check_access(input string nm, input bit w, input logic [3:0] a, input logic [31:0] wd);
    logic [31:0] e_rd, rd;
    int e_lat, e_push, e_pop, lat, push, pop;
    logic [7:0] e_pd, pd;
    bit clean;
    logic irqa;
    model_step(w, a, wd, tx_full, rx_empty, rx_pdata, e_rd, e_lat, e_push, e_pd, e_pop);
    do_access(w, a, wd, rd, lat, push, pd, pop, clean, irqa);
    chk({nm, "_rdata"}, rd, e_rd);
    chk({nm, "_lat"}, lat, e_lat);
    chk({nm, "_push"}, push, e_push);
    chk({nm, "_pdata"}, {24'h0, pd}, {24'h0, e_pd});
    chk({nm, "_pop"}, pop, e_pop);
    chk({nm, "_pulse_end"}, {31'h0, clean}, 32'h1);
    chk({nm, "_irq"}, {31'h0, irqa}, {31'h0, m_irq_en & ~rx_empty});
  endtask

  initial begin
    logic [31:0] rd, d_rd;
    int lat, push, pop, d_lat, d_push, d_pop, acks;
    logic [7:0] pd, d_pd;
    bit clean;
    logic irqa;

    tbl[0]  = '{1'b0, 4'hC, 32'h0,         1'b0, 1'b1, 8'h00, 32'h0000_0001, 1, 0, 8'h00, 0};
    tbl[1]  = '{1'b0, 4'h8, 32'h0,         1'b0, 1'b1, 8'h00, 32'h0000_0002, 1, 0, 8'h00, 0};
    tbl[2]  = '{1'b1, 4'h0, 32'h0000_00A5, 1'b0, 1'b1, 8'h00, 32'h0,         1, 1, 8'hA5, 0};
    tbl[3]  = '{1'b0, 4'h8, 32'h0,         1'b0, 1'b1, 8'h00, 32'h0001_0002, 1, 0, 8'h00, 0};
    tbl[4]  = '{1'b0, 4'h4, 32'h0,         1'b0, 1'b0, 8'h5A, 32'h0000_005A, 1, 0, 8'h00, 1};
    tbl[5]  = '{1'b0, 4'h4, 32'h0,         1'b0, 1'b1, 8'h77, 32'h0000_0100, 1, 0, 8'h00, 0};
    tbl[6]  = '{1'b1, 4'hC, 32'h0,         1'b0, 1'b1, 8'h00, 32'h0,         1, 0, 8'h00, 0};
    tbl[7]  = '{1'b1, 4'h0, 32'h0000_0011, 1'b1, 1'b1, 8'h00, 32'h0,         1, 0, 8'h00, 0};
    tbl[8]  = '{1'b0, 4'h8, 32'h0,         1'b1, 1'b1, 8'h00, 32'h0001_0007, 1, 0, 8'h00, 0};
    tbl[9]  = '{1'b1, 4'hC, 32'h0000_0003, 1'b0, 1'b1, 8'h00, 32'h0,         1, 0, 8'h00, 0};
    tbl[10] = '{1'b0, 4'hC, 32'h0,         1'b0, 1'b1, 8'h00, 32'h0000_0001, 1, 0, 8'h00, 0};
    tbl[11] = '{1'b0, 4'h8, 32'h0,         1'b0, 1'b0, 8'h33, 32'h0001_0000, 1, 0, 8'h00, 0};
    tbl[12] = '{1'b1, 4'h2, 32'h1234_563C, 1'b0, 1'b0, 8'h00, 32'h0,         1, 1, 8'h3C, 0};
    tbl[13] = '{1'b0, 4'h3, 32'h0,         1'b0, 1'b0, 8'h00, 32'h0,         1, 0, 8'h00, 0};
    tbl[14] = '{1'b1, 4'h4, 32'h0000_00FF, 1'b0, 1'b0, 8'h44, 32'h0,         1, 0, 8'h00, 0};
    tbl[15] = '{1'b1, 4'h8, 32'hFFFF_FFFF, 1'b0, 1'b1, 8'h00, 32'h0,         1, 0, 8'h00, 0};
    tbl[16] = '{1'b0, 4'hB, 32'h0,         1'b0, 1'b1, 8'h00, 32'h0002_0002, 1, 0, 8'h00, 0};

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_txv", {31'h0, txv}, 32'h0);
    chk("rst_rxr", {31'h0, rxr}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 17; i++) begin
      tx_full = tbl[i].full; rx_empty = tbl[i].empty; rx_pdata = tbl[i].pd;
      model_step(tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].full, tbl[i].empty, tbl[i].pd,
                 d_rd, d_lat, d_push, d_pd, d_pop);
      do_access(tbl[i].w, tbl[i].a, tbl[i].wd, rd, lat, push, pd, pop, clean, irqa);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_push", i), push, tbl[i].push);
      chk($sformatf("vec%0d_pdata", i), {24'h0, pd}, {24'h0, tbl[i].pdx});
      chk($sformatf("vec%0d_pop", i), pop, tbl[i].pop);
      chk($sformatf("vec%0d_pulse_end", i), {31'h0, clean}, 32'h1);
      chk($sformatf("vec%0d_irq", i), {31'h0, irqa}, 32'h0);
    end

    // Stall released: request in cycle N, full drops in N+4, push+ack in N+5
    tx_full = 1'b1; rx_empty = 1'b1;
    fork
      do_access(1'b1, 4'h0, 32'h0000_003C, rd, lat, push, pd, pop, clean, irqa);
      begin repeat (5) @(posedge clk); #1 tx_full = 1'b0; end
    join
    m_count = (m_count + 1) % (1 << CW);
    chk("stall_rel_lat", lat, 32'd5);
    chk("stall_rel_push", push, 32'd1);
    chk("stall_rel_pdata", {24'h0, pd}, 32'h3C);
    check_access("stall_rel_status", 1'b0, 4'h8, 32'h0);
    chk("stall_rel_status_const", 32'h0003_0002, {16'(m_count), 13'h0, m_ovf, 1'b1, 1'b0});

    // Stall timeout: full held, byte dropped after T+1 cycles
    tx_full = 1'b1;
    check_access("stall_to", 1'b1, 4'h0, 32'h0000_0099);
    tx_full = 1'b0;
    check_access("stall_to_status", 1'b0, 4'h8, 32'h0);
    chk("stall_to_ovf", {31'h0, m_ovf}, 32'h1);
    check_access("ovf_clr", 1'b1, 4'hC, 32'h0000_0003);
    check_access("ovf_clr_status", 1'b0, 4'h8, 32'h0);

    // Interrupt follows rx_empty one cycle later
    check_access("irq_en", 1'b1, 4'hC, 32'h0000_0005);
    @(posedge clk); #1 rx_empty = 1'b0;
    @(negedge clk); chk("irq_same_cycle", {31'h0, irq}, 32'h0);
    @(negedge clk); chk("irq_next_cycle", {31'h0, irq}, 32'h1);
    @(posedge clk); #1 rx_empty = 1'b1;
    @(negedge clk); chk("irq_fall_same", {31'h0, irq}, 32'h1);
    @(negedge clk); chk("irq_fall_next", {31'h0, irq}, 32'h0);

    // Reset in the middle of TX_WAIT: no ack, all outputs cleared
    rx_empty = 1'b0; tx_full = 1'b1; acks = 0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 4'h0; wdata = 32'h42;
    repeat (6) begin @(negedge clk); if (ack) acks++; end
    chk("irq_before_rst", {31'h0, irq}, 32'h1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk); if (ack) acks++;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_no_ack", acks, 32'd0);
    chk("rst_mid_ack", {31'h0, ack}, 32'h0);
    chk("rst_mid_txv", {31'h0, txv}, 32'h0);
    chk("rst_mid_txd", {24'h0, txd}, 32'h0);
    chk("rst_mid_rxr", {31'h0, rxr}, 32'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_irq", {31'h0, irq}, 32'h0);
    req = 1'b0; we = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; tx_full = 1'b0; rx_empty = 1'b1;
    model_reset();
    check_access("post_rst_ctrl", 1'b0, 4'hC, 32'h0);

    // Counter wrap at 2**CW accepted writes
    for (int i = 0; i < (1 << CW) - 1; i++)
      check_access("wrap_wr", 1'b1, 4'h0, $urandom);
    check_access("wrap_pre", 1'b0, 4'h8, 32'h0);
    check_access("wrap_last", 1'b1, 4'h0, 32'h0000_00EE);
    check_access("wrap_post", 1'b0, 4'h8, 32'h0);
    chk("wrap_zero", m_count, 32'd0);

    // Randomized accesses against the model
    for (int i = 0; i < 300; i++) begin
      tx_full  = ($urandom_range(0, 3) == 0);
      rx_empty = $urandom_range(0, 1);
      rx_pdata = 8'($urandom);
      check_access($sformatf("rnd%0d", i), 1'($urandom), 4'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
